soc_system_pio_in_irq: RTL and testbench

SOC_SYSTEM_PIO_IN_IRQ -- requirements
Module: soc_system_pio_in_irq

---
 rtl/soc_system_pio_in_irq.sv | 113 +++++++++++
 tb/tb_soc_system_pio_in_irq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/soc_system_pio_in_irq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : soc_system_pio_in_irq
// Brief   : Avalon-MM input PIO with synchronizer, edge capture and level IRQ.
// Revision: 1.0 - initial release
// ============================================================================
module soc_system_pio_in_irq #(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int              CNT_W      = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] data_sync;
  logic [WIDTH-1:0] data_prev;
  logic [WIDTH-1:0] edge_sel;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] clr_mask;
  logic [CNT_W-1:0] settle_cnt;
  logic             settled;
  logic             wr_en;
  logic [31:0]      rd_next;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= '0;
      data_prev <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], in_port};
      data_prev <= data_sync;
    end
  end

  assign data_sync = sync_q[SYNC_STAGES-1];

  if (EDGE_TYPE == 0) begin : g_edge_rise
    assign edge_sel = data_sync & ~data_prev;
  end else if (EDGE_TYPE == 1) begin : g_edge_fall
    assign edge_sel = ~data_sync & data_prev;
  end else begin : g_edge_any
    assign edge_sel = data_sync ^ data_prev;
  end

  // Suppress edges until the chain and data_prev hold real post-reset input,
  // so a level already present at reset release is not seen as an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      settle_cnt <= '0;
    end else if (!settled) begin
      settle_cnt <= settle_cnt + 1'b1;
    end
  end

  assign settled  = (settle_cnt == SETTLE_MAX);
  assign edge_det = settled ? edge_sel : '0;

  assign wr_en    = chipselect & ~write_n;
  assign clr_mask = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // New edges are OR-ed after the clear so a same-cycle edge wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecapture <= '0;
      irqmask     <= '0;
      irq         <= 1'b0;
    end else begin
      edgecapture <= (edgecapture & ~clr_mask) | edge_det;
      if (wr_en && address == 2'd2) begin
        irqmask <= writedata[WIDTH-1:0];
      end
      irq <= |(edgecapture & irqmask);
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      2'd0:    rd_next[WIDTH-1:0] = data_sync;
      2'd2:    rd_next[WIDTH-1:0] = irqmask;
      2'd3:    rd_next[WIDTH-1:0] = edgecapture;
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_soc_system_pio_in_irq.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for soc_system_pio_in_irq: rising-edge instance plus any-edge instance
// on a shared bus, with a readdata scoreboard.
module tb_soc_system_pio_in_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd0, rd2;
  logic        irq0, irq2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp0_q[$];
  logic [31:0] exp2_q[$];
  logic [31:0] e0, e2;

  always #5 clk = ~clk;

  soc_system_pio_in_irq #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd0), .irq(irq0)
  );

  soc_system_pio_in_irq #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd2), .irq(irq2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic issue_read(input logic [1:0] a, input logic [31:0] e);
    address = a;
    exp0_q.push_back(e);
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_checks++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL reset_rd0: got %h want 0", rd0); end
    n_checks++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL reset_irq0: got %b want 0", irq0); end
    n_checks++; if (rd2 !== 32'h0) begin n_fail++; $display("FAIL reset_rd2: got %h want 0", rd2); end
    n_checks++; if (irq2 !== 1'b0) begin n_fail++; $display("FAIL reset_irq2: got %b want 0", irq2); end
    reset_n = 1'b1;
    repeat (4) tick();
    issue_read(2'd2, 32'h0); tick(); e0 = exp0_q.pop_front();
    n_checks++; if (rd0 !== e0) begin n_fail++; $display("FAIL reset_mask: got %h want %h", rd0, e0); end
    issue_read(2'd3, 32'h0); tick(); e0 = exp0_q.pop_front();
    n_checks++; if (rd0 !== e0) begin n_fail++; $display("FAIL reset_ecap: got %h want %h", rd0, e0); end
  endtask

  task automatic test_rise_capture();
    logic exp_irq;
    bus_write(2'd2, 32'h1);
    in_port = 8'h01;
    for (int k = 1; k <= 4; k++) issue_read(2'd3, (k >= 4) ? 32'h1 : 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      e0 = exp0_q.pop_front();
      exp_irq = (k >= 4);
      n_checks++; if (rd0 !== e0) begin n_fail++; $display("FAIL rise_rd cyc%0d: got %h want %h", k, rd0, e0); end
      n_checks++; if (irq0 !== exp_irq) begin n_fail++; $display("FAIL rise_irq cyc%0d: got %b want %b", k, irq0, exp_irq); end
    end
  endtask

  task automatic test_w1c();
    in_port = 8'h05;
    repeat (4) tick();
    issue_read(2'd3, 32'h5); tick(); e0 = exp0_q.pop_front();
    n_checks++; if (rd0 !== e0) begin n_fail++; $display("FAIL w1c_pre: got %h want %h", rd0, e0); end
    bus_write(2'd3, 32'h4);
    n_checks++; if (irq0 !== 1'b1) begin n_fail++; $display("FAIL w1c_irq_a: got %b want 1", irq0); end
    issue_read(2'd3, 32'h1); tick(); e0 = exp0_q.pop_front();
    n_checks++; if (rd0 !== e0) begin n_fail++; $display("FAIL w1c_rd: got %h want %h", rd0, e0); end
    n_checks++; if (irq0 !== 1'b1) begin n_fail++; $display("FAIL w1c_irq_b: got %b want 1", irq0); end
    bus_write(2'd3, 32'h1);
    n_checks++; if (irq0 !== 1'b1) begin n_fail++; $display("FAIL w1c_irq_c: got %b want 1", irq0); end
    issue_read(2'd3, 32'h0); tick(); e0 = exp0_q.pop_front();
    n_checks++; if (rd0 !== e0) begin n_fail++; $display("FAIL w1c_clr: got %h want %h", rd0, e0); end
    n_checks++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL w1c_irq_drop: got %b want 0", irq0); end
  endtask

  task automatic test_simultaneous();
    in_port = 8'h01;
    repeat (4) tick();
    in_port = 8'h05;
    repeat (2) tick();
    bus_write(2'd3, 32'h4);
    issue_read(2'd3, 32'h4); tick(); e0 = exp0_q.pop_front();
    n_checks++; if (rd0 !== e0) begin n_fail++; $display("FAIL simul_set_wins: got %h want %h", rd0, e0); end
    n_checks++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL simul_irq: got %b want 0", irq0); end
  endtask

  task automatic test_masking();
    bus_write(2'd2, 32'h0);
    in_port = 8'h00;
    repeat (4) tick();
    in_port = 8'hFF;
    repeat (4) tick();
    issue_read(2'd3, 32'hFF); tick(); e0 = exp0_q.pop_front();
    n_checks++; if (rd0 !== e0) begin n_fail++; $display("FAIL mask_ecap: got %h want %h", rd0, e0); end
    n_checks++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL mask_irq_off: got %b want 0", irq0); end
    bus_write(2'd2, 32'h1234_5680);
    n_checks++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL mask_irq_lat: got %b want 0", irq0); end
    issue_read(2'd2, 32'h80); tick(); e0 = exp0_q.pop_front();
    n_checks++; if (rd0 !== e0) begin n_fail++; $display("FAIL mask_rd: got %h want %h", rd0, e0); end
    n_checks++; if (irq0 !== 1'b1) begin n_fail++; $display("FAIL mask_irq_on: got %b want 1", irq0); end
    bus_write(2'd0, 32'h0);
    bus_write(2'd1, 32'hFFFF_FFFF);
    issue_read(2'd2, 32'h80); tick(); e0 = exp0_q.pop_front();
    n_checks++; if (rd0 !== e0) begin n_fail++; $display("FAIL noeff_mask: got %h want %h", rd0, e0); end
    issue_read(2'd3, 32'hFF); tick(); e0 = exp0_q.pop_front();
    n_checks++; if (rd0 !== e0) begin n_fail++; $display("FAIL noeff_ecap: got %h want %h", rd0, e0); end
    issue_read(2'd1, 32'h0); tick(); e0 = exp0_q.pop_front();
    n_checks++; if (rd0 !== e0) begin n_fail++; $display("FAIL rd_reserved: got %h want %h", rd0, e0); end
    issue_read(2'd0, 32'hFF); tick(); e0 = exp0_q.pop_front();
    n_checks++; if (rd0 !== e0) begin n_fail++; $display("FAIL rd_data: got %h want %h", rd0, e0); end
  endtask

  task automatic test_reset_mid();
    address = 2'd3;
    tick();
    in_port = 8'h00;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (rd0 !== 32'h0) begin n_fail++; $display("FAIL midrst_rd: got %h want 0", rd0); end
    n_checks++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL midrst_irq: got %b want 0", irq0); end
    in_port = 8'hFF;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (6) tick();
    issue_read(2'd3, 32'h0); tick(); e0 = exp0_q.pop_front();
    n_checks++; if (rd0 !== e0) begin n_fail++; $display("FAIL high_rel_ecap: got %h want %h", rd0, e0); end
    n_checks++; if (rd2 !== 32'h0) begin n_fail++; $display("FAIL high_rel_ecap2: got %h want 0", rd2); end
    n_checks++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL high_rel_irq: got %b want 0", irq0); end
    issue_read(2'd2, 32'h0); tick(); e0 = exp0_q.pop_front();
    n_checks++; if (rd0 !== e0) begin n_fail++; $display("FAIL high_rel_mask: got %h want %h", rd0, e0); end
  endtask

  task automatic test_any_edge();
    reset_n = 1'b0; in_port = 8'h00;
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    bus_write(2'd2, 32'h80);
    // Full pulse 0 -> 1 -> 0: both instances end with bit7 set.
    address = 2'd3;
    in_port = 8'h80; repeat (5) tick();
    in_port = 8'h00; repeat (4) tick();
    exp0_q.push_back(32'h80); exp2_q.push_back(32'h80);
    tick(); e0 = exp0_q.pop_front(); e2 = exp2_q.pop_front();
    n_checks++; if (rd0 !== e0) begin n_fail++; $display("FAIL pulse_rise_inst: got %h want %h", rd0, e0); end
    n_checks++; if (rd2 !== e2) begin n_fail++; $display("FAIL pulse_any_inst: got %h want %h", rd2, e2); end
    n_checks++; if (irq2 !== 1'b1) begin n_fail++; $display("FAIL pulse_any_irq: got %b want 1", irq2); end
    bus_write(2'd3, 32'h80);
    address = 2'd3;
    repeat (4) tick();
    exp0_q.push_back(32'h0); exp2_q.push_back(32'h0);
    tick(); e0 = exp0_q.pop_front(); e2 = exp2_q.pop_front();
    n_checks++; if (rd2 !== e2) begin n_fail++; $display("FAIL stable_any: got %h want %h", rd2, e2); end
    n_checks++; if (rd0 !== e0) begin n_fail++; $display("FAIL stable_rise: got %h want %h", rd0, e0); end
    n_checks++; if (irq2 !== 1'b0) begin n_fail++; $display("FAIL stable_any_irq: got %b want 0", irq2); end
    // Clear after the rise so only the any-edge instance recaptures the fall.
    in_port = 8'h80; repeat (3) tick();
    exp0_q.push_back(32'h80); exp2_q.push_back(32'h80);
    tick(); e0 = exp0_q.pop_front(); e2 = exp2_q.pop_front();
    n_checks++; if (rd0 !== e0) begin n_fail++; $display("FAIL rise2_rise_inst: got %h want %h", rd0, e0); end
    n_checks++; if (rd2 !== e2) begin n_fail++; $display("FAIL rise2_any_inst: got %h want %h", rd2, e2); end
    bus_write(2'd3, 32'h80);
    in_port = 8'h00; address = 2'd3;
    repeat (4) tick();
    exp0_q.push_back(32'h0); exp2_q.push_back(32'h80);
    tick(); e0 = exp0_q.pop_front(); e2 = exp2_q.pop_front();
    n_checks++; if (rd0 !== e0) begin n_fail++; $display("FAIL fall_rise_inst: got %h want %h", rd0, e0); end
    n_checks++; if (rd2 !== e2) begin n_fail++; $display("FAIL fall_any_inst: got %h want %h", rd2, e2); end
    n_checks++; if (irq2 !== 1'b1) begin n_fail++; $display("FAIL fall_any_irq: got %b want 1", irq2); end
    n_checks++; if (irq0 !== 1'b0) begin n_fail++; $display("FAIL fall_rise_irq: got %b want 0", irq0); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 8'h00;
    test_reset();
    test_rise_capture();
    test_w1c();
    test_simultaneous();
    test_masking();
    test_reset_mid();
    test_any_edge();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
